// File: rtl/apb_req_arbiter_if.sv
// Requester, response and bridge command bundle for apb_req_arbiter.
// slave = arbiter side, master = requester/bridge side.
interface apb_req_arbiter_if #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 8
);
  logic          req0_valid;
  logic          req0_ready;
  logic          req0_write;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid;
  logic          req1_ready;
  logic          req1_write;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;

  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;
  logic          rsp0_err;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;
  logic          rsp1_err;

  logic          transfer;
  logic          read_write;
  logic [AW-1:0] apb_write_paddr;
  logic [AW-1:0] apb_read_paddr;
  logic [DW-1:0] apb_write_data;
  logic [DW-1:0] apb_read_data_out;
  logic          xfer_done;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp0_err,
    output rsp1_valid, rsp1_rdata, rsp1_err,
    output transfer, read_write, apb_write_paddr, apb_read_paddr, apb_write_data,
    input  apb_read_data_out, xfer_done
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp0_err,
    input  rsp1_valid, rsp1_rdata, rsp1_err,
    input  transfer, read_write, apb_write_paddr, apb_read_paddr, apb_write_data,
    output apb_read_data_out, xfer_done
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of the APB master bridge.
// Optional watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
  parameter int unsigned AW             = 9,
  parameter int unsigned DW             = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  apb_req_arbiter_if.slave bus
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_req_arbiter: TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  state_e state_q, state_n;
  logic   last_grant_q;
  logic   gnt_idx_q;
  logic   cmd_write_q;
  logic   gnt0_c, gnt1_c;
  logic   accept_c;
  logic   sel_c;
  logic   timeout_c;
  logic   exit_xfer_c;
  cmd_t   sel_cmd_c;

  // Round-robin: on a tie the requester not granted last wins.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt0_c = last_grant_q;
      gnt1_c = !last_grant_q;
    end else begin
      gnt0_c = bus.req0_valid;
      gnt1_c = bus.req1_valid;
    end
  end

  assign bus.req0_ready = (state_q == IDLE) && gnt0_c;
  assign bus.req1_ready = (state_q == IDLE) && gnt1_c;
  assign accept_c       = bus.req0_ready || bus.req1_ready;
  assign sel_c          = bus.req1_ready;

  always_comb begin
    sel_cmd_c = '0;
    if (sel_c) sel_cmd_c = '{write: bus.req1_write, addr: bus.req1_addr, wdata: bus.req1_wdata};
    else       sel_cmd_c = '{write: bus.req0_write, addr: bus.req0_addr, wdata: bus.req0_wdata};
  end

`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt_q;

  // Watchdog: counts XFER cycles without completion; xfer_done wins a same-cycle race.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)                                  wd_cnt_q <= 8'd0;
    else if (accept_c)                             wd_cnt_q <= 8'd0;
    else if (state_q == XFER && !bus.xfer_done)    wd_cnt_q <= wd_cnt_q + 8'd1;
  end

  assign timeout_c = (state_q == XFER) && !bus.xfer_done &&
                     (wd_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  assign exit_xfer_c = (state_q == XFER) && (state_n == RESP);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_n = XFER;
      XFER:    if (bus.xfer_done || timeout_c) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered command to the bridge and responses to the requesters.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      last_grant_q        <= 1'b1;
      gnt_idx_q           <= 1'b0;
      cmd_write_q         <= 1'b0;
      bus.transfer        <= 1'b0;
      bus.read_write      <= 1'b0;
      bus.apb_write_paddr <= '0;
      bus.apb_read_paddr  <= '0;
      bus.apb_write_data  <= '0;
      bus.rsp0_valid      <= 1'b0;
      bus.rsp0_rdata      <= '0;
      bus.rsp0_err        <= 1'b0;
      bus.rsp1_valid      <= 1'b0;
      bus.rsp1_rdata      <= '0;
      bus.rsp1_err        <= 1'b0;
    end else begin
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      if (accept_c) begin
        last_grant_q        <= sel_c;
        gnt_idx_q           <= sel_c;
        cmd_write_q         <= sel_cmd_c.write;
        bus.transfer        <= 1'b1;
        bus.read_write      <= sel_cmd_c.write;
        bus.apb_write_paddr <= sel_cmd_c.write ? sel_cmd_c.addr  : '0;
        bus.apb_read_paddr  <= sel_cmd_c.write ? '0 : sel_cmd_c.addr;
        bus.apb_write_data  <= sel_cmd_c.write ? sel_cmd_c.wdata : '0;
      end
      if (exit_xfer_c) begin
        bus.transfer        <= 1'b0;
        bus.read_write      <= 1'b0;
        bus.apb_write_paddr <= '0;
        bus.apb_read_paddr  <= '0;
        bus.apb_write_data  <= '0;
        if (gnt_idx_q) begin
          bus.rsp1_valid <= 1'b1;
          bus.rsp1_rdata <= (cmd_write_q || timeout_c) ? '0 : bus.apb_read_data_out;
          bus.rsp1_err   <= timeout_c;
        end else begin
          bus.rsp0_valid <= 1'b1;
          bus.rsp0_rdata <= (cmd_write_q || timeout_c) ? '0 : bus.apb_read_data_out;
          bus.rsp0_err   <= timeout_c;
        end
      end
    end
  end

endmodule
